// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding system (both requesters plus the RAM read-data return).
interface ram_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [15:0] a_adr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;

    logic        b_req;
    logic        b_we;
    logic [15:0] b_adr;
    logic [7:0]  b_wdata;
    logic        b_ack;
    logic [7:0]  b_rdata;

    logic [15:0] ram_adr;
    logic        ram_rwn;
    logic        ram_cs;
    logic [7:0]  ram_data_i;
    logic [7:0]  ram_data_o;

    modport slave (
        input  a_req, a_we, a_adr, a_wdata,
        input  b_req, b_we, b_adr, b_wdata,
        input  ram_data_o,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_adr, ram_rwn, ram_cs, ram_data_i
    );

    modport master (
        output a_req, a_we, a_adr, a_wdata,
        output b_req, b_we, b_adr, b_wdata,
        output ram_data_o,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_adr, ram_rwn, ram_cs, ram_data_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port RAM with a registered
// read. Requests are serialised through IDLE -> ISSUE -> (CAPTURE) -> ACK.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | sample a_req/b_req, pick a winner, latch its command
// ISSUE    | RAM selected for one cycle; writes commit at the end of it
// CAPTURE  | reads only: registered RAM data is valid, load granted rdata
// ACK      | one-cycle ack to the granted port; requests ignored
module ram_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_gnt;
    logic        r_we;
    logic [15:0] r_adr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;
    logic        w_grant_valid;
    logic        w_grant_b;

    // Winner selection for the IDLE cycle; a tie in round-robin mode goes to
    // whichever port was not served last.
    always_comb begin
        w_grant_valid = bus.a_req | bus.b_req;
        w_grant_b     = bus.b_req;
        if (bus.a_req && bus.b_req) begin
            w_grant_b = (PRIO_MODE != 0) ? (r_last_grant == GNT_A) : GNT_A;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the state-decoded RAM strobes and acks. Chip select is
    // decoded from the state so an async reset in ISSUE kills it immediately.
    always_comb begin
        w_state_nxt = r_state;
        bus.ram_cs  = 1'b0;
        bus.ram_rwn = 1'b1;
        bus.a_ack   = 1'b0;
        bus.b_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.ram_cs  = 1'b1;
                bus.ram_rwn = ~r_we;
                w_state_nxt = r_we ? S_ACK : S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                bus.a_ack   = (r_gnt == GNT_A);
                bus.b_ack   = (r_gnt == GNT_B);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch on grant and read-data capture into the granted port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GNT_B;
            r_gnt        <= GNT_A;
            r_we         <= 1'b0;
            r_adr        <= 16'h0000;
            r_wdata      <= 8'h00;
            r_a_rdata    <= 8'h00;
            r_b_rdata    <= 8'h00;
        end else begin
            if (r_state == S_IDLE && w_grant_valid) begin
                r_gnt        <= w_grant_b;
                r_last_grant <= w_grant_b;
                r_we         <= w_grant_b ? bus.b_we    : bus.a_we;
                r_adr        <= w_grant_b ? bus.b_adr   : bus.a_adr;
                r_wdata      <= w_grant_b ? bus.b_wdata : bus.a_wdata;
            end
            if (r_state == S_CAPTURE) begin
                if (r_gnt == GNT_B) begin
                    r_b_rdata <= bus.ram_data_o;
                end else begin
                    r_a_rdata <= bus.ram_data_o;
                end
            end
        end
    end

    assign bus.ram_adr    = r_adr;
    assign bus.ram_data_i = r_wdata;
    assign bus.a_rdata    = r_a_rdata;
    assign bus.b_rdata    = r_b_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one fixed-priority and one round-robin instance,
// each behind a behavioural single-port RAM with registered read.
`timescale 1ns/1ps
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if u_if0 ();
    ram_arbiter_if u_if1 ();

    ram_arbiter #(.PRIO_MODE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
    ram_arbiter #(.PRIO_MODE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];
    logic [7:0] ref0 [0:65535];
    logic [7:0] exp_a0, exp_b0;

    // reset-value bundle: {a_ack,b_ack,a_rdata,b_rdata,cs,rwn,adr,data_i}
    localparam logic [43:0] RST_BUNDLE = {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00};

    // RAM models: registered read of the presented address, write on cs & !rwn
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[0] = 8'h11; mem0[1] = 8'h22;
        mem1[0] = 8'h33; mem1[1] = 8'h44;
        u_if0.ram_data_o = 8'h00;
        u_if1.ram_data_o = 8'h00;
        forever begin
            @(posedge clk);
            u_if0.ram_data_o <= mem0[u_if0.ram_adr];
            u_if1.ram_data_o <= mem1[u_if1.ram_adr];
            if (u_if0.ram_cs && !u_if0.ram_rwn) mem0[u_if0.ram_adr] = u_if0.ram_data_i;
            if (u_if1.ram_cs && !u_if1.ram_rwn) mem1[u_if1.ram_adr] = u_if1.ram_data_i;
        end
    end

    function automatic logic [43:0] bundle0();
        return {u_if0.a_ack, u_if0.b_ack, u_if0.a_rdata, u_if0.b_rdata,
                u_if0.ram_cs, u_if0.ram_rwn, u_if0.ram_adr, u_if0.ram_data_i};
    endfunction

    // Drives one transaction on DUT0 and reports ack latency (-1 on timeout)
    // and what the RAM pins showed while selected.
    task automatic txn0(input bit pb, input bit we, input logic [15:0] adr, input logic [7:0] wd,
                        output int lat, output int cs_cnt, output logic rwn_cs,
                        output logic [15:0] adr_cs, output logic [7:0] d_cs);
        @(negedge clk);
        if (pb) begin
            u_if0.b_req = 1'b1; u_if0.b_we = we; u_if0.b_adr = adr; u_if0.b_wdata = wd;
        end else begin
            u_if0.a_req = 1'b1; u_if0.a_we = we; u_if0.a_adr = adr; u_if0.a_wdata = wd;
        end
        lat = -1; cs_cnt = 0; rwn_cs = 1'bx; adr_cs = 'x; d_cs = 'x;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (u_if0.ram_cs) begin
                cs_cnt++; rwn_cs = u_if0.ram_rwn; adr_cs = u_if0.ram_adr; d_cs = u_if0.ram_data_i;
            end
            if (pb ? u_if0.b_ack : u_if0.a_ack) begin
                lat = i;
                break;
            end
        end
        if (pb) u_if0.b_req = 1'b0; else u_if0.a_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bundle0() !== RST_BUNDLE) begin
            failures++; $display("FAIL reset_values0 got=%h exp=%h", bundle0(), RST_BUNDLE);
        end
        checks++;
        if ({u_if1.a_ack, u_if1.b_ack, u_if1.ram_cs, u_if1.ram_rwn} !== 4'b0001) begin
            failures++; $display("FAIL reset_values1 got=%b exp=0001",
                                 {u_if1.a_ack, u_if1.b_ack, u_if1.ram_cs, u_if1.ram_rwn});
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (u_if0.a_ack || u_if0.b_ack || u_if0.ram_cs) begin
                failures++; $display("FAIL reset_release_quiet got=%b exp=000",
                                     {u_if0.a_ack, u_if0.b_ack, u_if0.ram_cs});
            end
        end
    endtask

    task automatic test_write_read();
        int lat, csc; logic rwn; logic [15:0] ad; logic [7:0] d;
        txn0(1'b0, 1'b1, 16'h1234, 8'h5A, lat, csc, rwn, ad, d);
        ref0[16'h1234] = 8'h5A;
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++;
        if ({csc, rwn, ad, d} !== {32'd1, 1'b0, 16'h1234, 8'h5A}) begin
            failures++; $display("FAIL wr_pins got cs_cycles=%0d rwn=%b adr=%h d=%h exp 1/0/1234/5a", csc, rwn, ad, d);
        end
        txn0(1'b0, 1'b0, 16'h1234, 8'h00, lat, csc, rwn, ad, d);
        exp_a0 = ref0[16'h1234];
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
        checks++;
        if (u_if0.a_rdata !== exp_a0) begin
            failures++; $display("FAIL rd_data got=%h exp=%h", u_if0.a_rdata, exp_a0);
        end
        checks++;
        if ({csc, rwn, ad} !== {32'd1, 1'b1, 16'h1234}) begin
            failures++; $display("FAIL rd_pins got cs_cycles=%0d rwn=%b adr=%h", csc, rwn, ad);
        end
        checks++;
        if (u_if0.b_rdata !== exp_b0) begin
            failures++; $display("FAIL rd_other_port got=%h exp=%h", u_if0.b_rdata, exp_b0);
        end
    endtask

    task automatic test_fixed_priority();
        int an = -1, bn = -1;
        @(negedge clk);
        u_if0.a_req = 1'b1; u_if0.a_we = 1'b0; u_if0.a_adr = 16'h0000;
        u_if0.b_req = 1'b1; u_if0.b_we = 1'b0; u_if0.b_adr = 16'h0001;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (u_if0.a_ack && an < 0) begin
                an = i; u_if0.a_req = 1'b0; exp_a0 = ref0[0];
                checks++;
                if (u_if0.a_rdata !== exp_a0) begin
                    failures++; $display("FAIL prio_a_data got=%h exp=%h", u_if0.a_rdata, exp_a0);
                end
            end
            if (u_if0.b_ack && bn < 0) begin
                bn = i; u_if0.b_req = 1'b0; exp_b0 = ref0[1];
                checks++;
                if (u_if0.b_rdata !== exp_b0) begin
                    failures++; $display("FAIL prio_b_data got=%h exp=%h", u_if0.b_rdata, exp_b0);
                end
            end
            if (an > 0 && bn > 0) break;
        end
        u_if0.a_req = 1'b0; u_if0.b_req = 1'b0;
        checks++;
        if (an !== 3 || bn !== 7) begin
            failures++; $display("FAIL prio_order got a_ack@%0d b_ack@%0d exp a@3 b@7", an, bn);
        end
    endtask

    task automatic test_starvation();
        int na = 0, nb = 0, bad = 0;
        @(negedge clk);
        u_if0.a_req = 1'b1; u_if0.a_we = 1'b0; u_if0.a_adr = 16'h1234;
        u_if0.b_req = 1'b1; u_if0.b_we = 1'b0; u_if0.b_adr = 16'h0001;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (u_if0.a_ack) begin
                na++;
                if (u_if0.a_rdata !== ref0[16'h1234] || (i % 4) != 3) bad++;
            end
            if (u_if0.b_ack) nb++;
        end
        checks++;
        if (na !== 10 || nb !== 0 || bad !== 0) begin
            failures++; $display("FAIL starve got a_acks=%0d b_acks=%0d bad=%0d exp 10/0/0", na, nb, bad);
        end
        u_if0.a_req = 1'b0;
        for (int i = 1; i <= 10 && nb == 0; i++) begin
            @(negedge clk);
            if (u_if0.b_ack) nb++;
        end
        u_if0.b_req = 1'b0;
        exp_a0 = ref0[16'h1234];
        exp_b0 = ref0[1];
        checks++;
        if (nb !== 1 || u_if0.b_rdata !== exp_b0) begin
            failures++; $display("FAIL starve_release got b_acks=%0d data=%h exp 1/%h", nb, u_if0.b_rdata, exp_b0);
        end
    endtask

    task automatic test_round_robin();
        int k = 0;
        @(negedge clk);
        u_if1.a_req = 1'b1; u_if1.a_we = 1'b0; u_if1.a_adr = 16'h0000;
        u_if1.b_req = 1'b1; u_if1.b_we = 1'b0; u_if1.b_adr = 16'h0001;
        for (int i = 1; i <= 40 && k < 8; i++) begin
            @(negedge clk);
            if (u_if1.a_ack || u_if1.b_ack) begin
                checks++;
                if ({u_if1.a_ack, u_if1.b_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || i != 3 + 4 * k) begin
                    failures++; $display("FAIL rr_grant k=%0d got acks=%b at %0d exp port %s at %0d",
                                         k, {u_if1.a_ack, u_if1.b_ack}, i, (k % 2 == 0) ? "A" : "B", 3 + 4 * k);
                end
                checks++;
                if ((u_if1.a_ack && u_if1.a_rdata !== 8'h33) || (u_if1.b_ack && u_if1.b_rdata !== 8'h44)) begin
                    failures++; $display("FAIL rr_data k=%0d got a=%h b=%h exp a=33 b=44", k, u_if1.a_rdata, u_if1.b_rdata);
                end
                k++;
            end
        end
        u_if1.a_req = 1'b0; u_if1.b_req = 1'b0;
        checks++;
        if (k !== 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", k); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_held_req();
        int an = -1;
        @(negedge clk);
        u_if0.a_req = 1'b1; u_if0.a_we = 1'b1; u_if0.a_adr = 16'h0100; u_if0.a_wdata = 8'hA1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (u_if0.a_ack) begin an = i; break; end
        end
        checks++;
        if (an !== 2 || u_if0.ram_cs !== 1'b0) begin
            failures++; $display("FAIL held_first got ack@%0d cs=%b exp ack@2 cs=0", an, u_if0.ram_cs);
        end
        ref0[16'h0100] = 8'hA1;
        u_if0.a_adr = 16'h0200; u_if0.a_wdata = 8'hA2;
        @(negedge clk);
        checks++;
        if (u_if0.ram_cs !== 1'b0 || u_if0.a_ack !== 1'b0) begin
            failures++; $display("FAIL held_dup got cs=%b ack=%b exp 0/0", u_if0.ram_cs, u_if0.a_ack);
        end
        @(negedge clk);
        checks++;
        if ({u_if0.ram_cs, u_if0.ram_rwn, u_if0.ram_adr, u_if0.ram_data_i} !== {1'b1, 1'b0, 16'h0200, 8'hA2}) begin
            failures++; $display("FAIL held_issue got cs=%b rwn=%b adr=%h d=%h exp 1/0/0200/a2",
                                 u_if0.ram_cs, u_if0.ram_rwn, u_if0.ram_adr, u_if0.ram_data_i);
        end
        @(negedge clk);
        checks++;
        if (u_if0.a_ack !== 1'b1) begin failures++; $display("FAIL held_ack2 got=%b exp=1", u_if0.a_ack); end
        u_if0.a_req = 1'b0;
        ref0[16'h0200] = 8'hA2;
    endtask

    task automatic test_reset_activity();
        @(negedge clk);
        u_if0.a_req = 1'b1; u_if0.a_we = 1'b0; u_if0.a_adr = 16'h0100;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bundle0() !== RST_BUNDLE) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h", bundle0(), RST_BUNDLE);
        end
        @(negedge clk);
        reset = 1'b0; u_if0.a_req = 1'b0;
        exp_a0 = 8'h00; exp_b0 = 8'h00;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (u_if0.a_ack || u_if0.b_ack) begin
                failures++; $display("FAIL reset_mid_noack got=%b exp=00", {u_if0.a_ack, u_if0.b_ack});
            end
        end
    endtask

    task automatic test_reset_during_write();
        int lat, csc, nack = 0; logic rwn; logic [15:0] ad; logic [7:0] d;
        @(negedge clk);
        u_if0.b_req = 1'b1; u_if0.b_we = 1'b1; u_if0.b_adr = 16'h0010; u_if0.b_wdata = 8'hFF;
        @(negedge clk);
        checks++;
        if (u_if0.ram_cs !== 1'b1) begin failures++; $display("FAIL rstw_issue got cs=%b exp=1", u_if0.ram_cs); end
        reset = 1'b1;
        #1;
        checks++;
        if ({u_if0.ram_cs, u_if0.ram_rwn} !== 2'b01) begin
            failures++; $display("FAIL rstw_cs got=%b exp=01", {u_if0.ram_cs, u_if0.ram_rwn});
        end
        @(negedge clk);
        reset = 1'b0; u_if0.b_req = 1'b0;
        exp_a0 = 8'h00; exp_b0 = 8'h00;
        repeat (4) begin
            @(negedge clk);
            if (u_if0.b_ack) nack++;
        end
        checks++;
        if (nack !== 0) begin failures++; $display("FAIL rstw_noack got=%0d exp=0", nack); end
        txn0(1'b1, 1'b0, 16'h0010, 8'h00, lat, csc, rwn, ad, d);
        exp_b0 = ref0[16'h0010];
        checks++;
        if (lat !== 3 || u_if0.b_rdata !== exp_b0) begin
            failures++; $display("FAIL rstw_reread got lat=%0d data=%h exp 3/%h", lat, u_if0.b_rdata, exp_b0);
        end
    endtask

    // random traffic on DUT0, tracked as pending transactions per port
    bit          rp_pend [2];
    bit          rp_iss  [2];
    bit          rp_we   [2];
    logic [15:0] rp_adr  [2];
    logic [7:0]  rp_wd   [2];
    int          rp_icyc [2];

    task automatic rnd_observe();
        bit ack [2];
        ack[0] = u_if0.a_ack; ack[1] = u_if0.b_ack;
        if (u_if0.ram_cs) begin
            int p = -1;
            for (int q = 0; q < 2; q++)
                if (rp_pend[q] && !rp_iss[q] && u_if0.ram_adr == rp_adr[q] && u_if0.ram_rwn == !rp_we[q] &&
                    (!rp_we[q] || u_if0.ram_data_i == rp_wd[q])) p = q;
            checks++;
            if (p < 0) begin
                failures++; $display("FAIL rnd_issue got adr=%h rwn=%b d=%h matches no pending request",
                                     u_if0.ram_adr, u_if0.ram_rwn, u_if0.ram_data_i);
            end else begin
                rp_iss[p] = 1'b1; rp_icyc[p] = cyc;
                checks++;
                if (p == 1 && rp_pend[0] && !rp_iss[0]) begin
                    failures++; $display("FAIL rnd_priority got B issued exp A first (A pending adr=%h)", rp_adr[0]);
                end
            end
        end
        checks++;
        if (ack[0] && ack[1]) begin failures++; $display("FAIL rnd_dual_ack got=11 exp one at most"); end
        for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
                checks++;
                if (!(rp_pend[p] && rp_iss[p]) || cyc - rp_icyc[p] != (rp_we[p] ? 1 : 2)) begin
                    failures++; $display("FAIL rnd_ack port=%0d got pend=%b iss=%b delay=%0d exp delay %0d",
                                         p, rp_pend[p], rp_iss[p], cyc - rp_icyc[p], rp_we[p] ? 1 : 2);
                end
                if (rp_we[p]) ref0[rp_adr[p]] = rp_wd[p];
                else if (p == 0) exp_a0 = ref0[rp_adr[p]];
                else exp_b0 = ref0[rp_adr[p]];
                rp_pend[p] = 1'b0; rp_iss[p] = 1'b0;
                if (p == 0) u_if0.a_req = 1'b0; else u_if0.b_req = 1'b0;
            end
        end
        checks++;
        if (u_if0.a_rdata !== exp_a0 || u_if0.b_rdata !== exp_b0) begin
            failures++; $display("FAIL rnd_rdata got a=%h b=%h exp a=%h b=%h",
                                 u_if0.a_rdata, u_if0.b_rdata, exp_a0, exp_b0);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 2; p++) begin rp_pend[p] = 1'b0; rp_iss[p] = 1'b0; end
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rnd_observe();
            for (int p = 0; p < 2; p++) begin
                if (!rp_pend[p] && $urandom_range(0, 3) == 0) begin
                    rp_pend[p] = 1'b1;
                    rp_we[p]   = 1'($urandom_range(0, 1));
                    rp_adr[p]  = 16'h0040 + 16'(8 * p) + 16'($urandom_range(0, 7));
                    rp_wd[p]   = 8'($urandom_range(0, 255));
                    if (p == 0) begin
                        u_if0.a_req = 1'b1; u_if0.a_we = rp_we[p]; u_if0.a_adr = rp_adr[p]; u_if0.a_wdata = rp_wd[p];
                    end else begin
                        u_if0.b_req = 1'b1; u_if0.b_we = rp_we[p]; u_if0.b_adr = rp_adr[p]; u_if0.b_wdata = rp_wd[p];
                    end
                end
            end
        end
        for (int n = 0; n < 40 && (rp_pend[0] || rp_pend[1]); n++) begin
            @(negedge clk);
            rnd_observe();
        end
        checks++;
        if (rp_pend[0] || rp_pend[1]) begin
            failures++; $display("FAIL rnd_drain got pending a=%b b=%b exp none", rp_pend[0], rp_pend[1]);
        end
    endtask

    initial begin
        reset = 1'b1;
        u_if0.a_req = 1'b0; u_if0.a_we = 1'b0; u_if0.a_adr = 16'h0; u_if0.a_wdata = 8'h0;
        u_if0.b_req = 1'b0; u_if0.b_we = 1'b0; u_if0.b_adr = 16'h0; u_if0.b_wdata = 8'h0;
        u_if1.a_req = 1'b0; u_if1.a_we = 1'b0; u_if1.a_adr = 16'h0; u_if1.a_wdata = 8'h0;
        u_if1.b_req = 1'b0; u_if1.b_we = 1'b0; u_if1.b_adr = 16'h0; u_if1.b_wdata = 8'h0;
        for (int i = 0; i < 65536; i++) ref0[i] = 8'h00;
        ref0[0] = 8'h11; ref0[1] = 8'h22;
        exp_a0 = 8'h00; exp_b0 = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_fixed_priority();
        test_starvation();
        test_round_robin();
        test_held_req();
        test_reset_activity();
        test_reset_during_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the 64 KiB single-port instruction/data RAM. The RAM has a 1-cycle registered read and a synchronous write qualified by `cs` and `!rwn`. Port A (Z80 CPU) and port B (loader/DMA/video fetch) each issue single-byte read or write requests over a req/ack handshake. The arbiter serialises these requests, drives the RAM control pins and returns read data to the granted port.

## Interface
- `PRIO_MODE`, 0, arbitration policy: 0 = fixed priority, A over B; 1 = round-robin between A and B
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a_req`  in  1  port A request; held high with `a_we`/`a_adr`/`a_wdata` stable until `a_ack`
- `a_we`  in  1  port A: 1 = write, 0 = read
- `a_adr`  in  16  port A byte address
- `a_wdata`  in  8  port A write data
- `a_ack`  out  1  port A completion; 1-cycle pulse
- `a_rdata`  out  8  port A read data; valid when `a_ack`=1 for a read, held until port A's next read completes
- `b_req`, `b_we`, `b_adr`, `b_wdata`, `b_ack`, `b_rdata`: identical to the port A signals, for port B
- `ram_adr`  out  16  RAM address
- `ram_rwn`  out  1  RAM read/write-not
- `ram_cs`  out  1  RAM chip select (write enable qualifier)
- `ram_data_i`  out  8  RAM write data
- `ram_data_o`  in  8  RAM read data; registered inside the RAM, valid the cycle after the address is presented

## Operation
- Four-state FSM: IDLE, ISSUE, CAPTURE, ACK.
- **IDLE**
  - Samples `a_req` and `b_req`. If neither is high, stay in IDLE.
  - If only one is high, grant that port.
  - If both are high:
    - `PRIO_MODE`=0: grant A.
    - `PRIO_MODE`=1: grant the port not granted last. `last_grant` resets to B, so A wins the first tie.
  - On grant, latch the winner's `we`/`adr`/`wdata` into the registered RAM outputs, record `last_grant`, and go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive `ram_cs`=1, `ram_adr` = latched address, `ram_rwn` = `!we`, `ram_data_i` = latched wdata.
  - For a write, the RAM writes at the end of this cycle; next state is ACK.
  - For a read, next state is CAPTURE.
- **CAPTURE** (reads only)
  - `ram_data_o` is valid in this cycle.
  - At the end of the cycle, load it into the granted port's rdata register and go to ACK.
- **ACK**
  - Granted port's ack = 1 for this single cycle.
  - All `req` inputs are ignored in this cycle, so a req still high from the completed transaction cannot be re-served.
  - Next state is IDLE.
- A requester that keeps `req` high after ack, with new address/data, is issuing a new request. It is sampled in the following IDLE cycle.
- Non-granted port: ack stays 0 and its rdata is unchanged.
- Write transactions never modify `a_rdata`/`b_rdata`.
- `ram_cs`=1 only in ISSUE. In every other state `ram_rwn`=1, and `ram_adr`/`ram_data_i` hold their last values.
- `PRIO_MODE`=0 can starve B while A requests continuously. This is intended: the CPU has priority.

## Timing
- Reset values (applied asynchronously on `reset` high):
  - state = IDLE, `last_grant` = B
  - `a_ack` = `b_ack` = 0, `a_rdata` = `b_rdata` = 0x00
  - `ram_cs` = 0, `ram_rwn` = 1, `ram_adr` = 0x0000, `ram_data_i` = 0x00
- Write latency: req sampled in IDLE cycle C0; ISSUE in C1; ack in C2.
- Read latency: req sampled in C0; ISSUE in C1; CAPTURE in C2; ack with rdata valid in C3.
- Peak throughput: one read per 4 cycles, one write per 3 cycles. A back-to-back request reaches ISSUE 2 cycles after the previous ack.
- Simultaneous requests are resolved in the same IDLE cycle. The loser keeps `req` high and is re-evaluated in the next IDLE.
- Reset mid-transaction:
  - Any state returns to IDLE immediately and no ack is produced.
  - Reset asserted during ISSUE before the clock edge forces `ram_cs`=0, so the write is aborted and memory is unchanged.
  - Requesters must reissue after reset.
- `req` is not sampled during reset. The first sample is the first IDLE cycle after `reset` deasserts.

## Test plan
- **Reset:** assert `reset` during activity -> all outputs at their reset values within the same cycle; no ack is issued for 2 cycles after release with reqs low.
- **Port A write then read:** A writes 0x5A to 0x1234 -> `a_ack` at C2, `ram_cs` high for exactly 1 cycle with `ram_rwn`=0. A then reads 0x1234 -> `a_ack` at C3 with `a_rdata`=0x5A; `b_rdata` unchanged.
- **Fixed priority:** with `PRIO_MODE`=0, A and B both read in the same cycle (A 0x0000 = 0x11, B 0x0001 = 0x22) -> A acked first with 0x11, B acked 4 cycles later with 0x22. With A requesting continuously, B is never acked.
- **Round-robin:** with `PRIO_MODE`=1, A and B both hold reads continuously -> grants alternate A, B, A, B starting with A; each ack is 4 cycles apart.
- **Reset during write:** reset asserted in the ISSUE cycle of a B write of 0xFF to 0x0010 (previous content 0x00) -> no `b_ack`; a re-read of 0x0010 returns 0x00.
- **Held req:** A keeps `a_req` high after `a_ack` with a new address -> no duplicate service in the ACK cycle; the next ISSUE uses the new address exactly 2 cycles after the previous ack.
